// File: rtl/fns_equiv_pkg.sv
// Shared definitions for the fns equivalence sequencer: FSM state encoding,
// the four-valued 2-bit code points and width helpers.
package fns_equiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_COMPARE = 3'd2,
        ST_REPORT  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Four-valued signal codes as they appear on in_code/spec_code/impl_code.
    localparam logic [1:0] L0 = 2'b00;
    localparam logic [1:0] L1 = 2'b01;
    localparam logic [1:0] LX = 2'b10;
    localparam logic [1:0] LZ = 2'b11;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of a code vector covering nbits four-valued signals.
    function automatic int code_w(input int nbits);
        return 2 * nbits;
    endfunction

endpackage

// File: rtl/fns_equiv_sequencer_grp_compare.sv
// One output-port comparator: flags any difference between the spec and impl
// codes of a single GRP_W-bit port.
module fns_grp_compare
    import fns_equiv_pkg::*;
#(
    parameter int GRP_W = 4
) (
    input  logic [2*GRP_W-1:0] spec_grp,
    input  logic [2*GRP_W-1:0] impl_grp,
    output logic               mismatch
);

    // The codes are plain binary, so ordinary inequality already keeps LX and
    // LZ apart; this is the case-inequality of the four-valued signals.
    always_comb begin
        mismatch = (spec_grp != impl_grp);
    end

endmodule

// File: rtl/fns_equiv_sequencer.sv
// Walks a spec/impl block pair through every four-valued input pattern,
// holds each pattern for SETTLE cycles, compares the outputs port by port,
// streams one result per pattern and keeps a run summary.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no run; outputs quiet, waiting for start
// WAIT    | pattern applied on in_code, settle down-counter running
// COMPARE | spec/impl sampled, per-port mismatch and summary updated
// REPORT  | res_valid high until the logger accepts the result
// DONE    | run complete; summary held until the next start
module fns_equiv_sequencer
    import fns_equiv_pkg::*;
#(
    parameter int NBITS  = 4,
    parameter int GRP_W  = 4,
    parameter int NGRP   = 6,
    parameter int SETTLE = 10,
    localparam int NPAT  = 1 << (2 * NBITS),
    localparam int NOUT  = GRP_W * NGRP,
    localparam int PAT_W = code_w(NBITS),
    localparam int CNT_W = cnt_w(NPAT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic [PAT_W-1:0]   in_code,
    input  logic [2*NOUT-1:0]  spec_code,
    input  logic [2*NOUT-1:0]  impl_code,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [PAT_W-1:0]   res_pat,
    output logic [NGRP-1:0]    res_grp_fail,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   mismatch_count,
    output logic               first_fail_valid,
    output logic [PAT_W-1:0]   first_fail_pat,
    output logic [NGRP-1:0]    fail_mask
);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_WAIT    = ST_WAIT;
    localparam logic [2:0] S_COMPARE = ST_COMPARE;
    localparam logic [2:0] S_REPORT  = ST_REPORT;
    localparam logic [2:0] S_DONE    = ST_DONE;

    localparam logic [7:0]       SETTLE_LD = 8'(SETTLE - 1);
    localparam logic [PAT_W-1:0] PAT_LAST  = PAT_W'(NPAT - 1);
    localparam logic [CNT_W-1:0] MM_MAX    = CNT_W'(NPAT);

    logic [2:0]       state;
    logic [PAT_W-1:0] pat_cnt;
    logic [7:0]       settle_cnt;
    logic [NGRP-1:0]  grp_fail;
    logic [NGRP-1:0]  grp_fail_q;
    logic [CNT_W-1:0] mm_cnt;
    logic             ff_valid;
    logic [PAT_W-1:0] ff_pat;
    logic [NGRP-1:0]  mask_q;

    // Group g covers output port o(NGRP-g), so o1 lands on the MSB.
    for (genvar g = 0; g < NGRP; g++) begin : g_cmp
        fns_grp_compare #(.GRP_W(GRP_W)) u_cmp (
            .spec_grp (spec_code[2*GRP_W*g +: 2*GRP_W]),
            .impl_grp (impl_code[2*GRP_W*g +: 2*GRP_W]),
            .mismatch (grp_fail[g])
        );
    end

    // Sequencer FSM, settle down-counter, pattern counter and run summary.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state      <= S_IDLE;
            pat_cnt    <= '0;
            settle_cnt <= '0;
            grp_fail_q <= '0;
            mm_cnt     <= '0;
            ff_valid   <= 1'b0;
            ff_pat     <= '0;
            mask_q     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_WAIT;
                        pat_cnt    <= '0;
                        settle_cnt <= SETTLE_LD;
                        grp_fail_q <= '0;
                        mm_cnt     <= '0;
                        ff_valid   <= 1'b0;
                        ff_pat     <= '0;
                        mask_q     <= '0;
                    end
                end
                S_WAIT: begin
                    if (settle_cnt == 8'd0) begin
                        state <= S_COMPARE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                S_COMPARE: begin
                    grp_fail_q <= grp_fail;
                    mask_q     <= mask_q | grp_fail;
                    if (|grp_fail) begin
                        if (mm_cnt != MM_MAX) begin
                            mm_cnt <= mm_cnt + CNT_W'(1);
                        end
                        if (!ff_valid) begin
                            ff_valid <= 1'b1;
                            ff_pat   <= pat_cnt;
                        end
                    end
                    state <= S_REPORT;
                end
                S_REPORT: begin
                    if (res_ready) begin
                        if (pat_cnt == PAT_LAST) begin
                            state <= S_DONE;
                        end else begin
                            pat_cnt    <= pat_cnt + PAT_W'(1);
                            settle_cnt <= SETTLE_LD;
                            state      <= S_WAIT;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status and result outputs decoded from the registered state.
    always_comb begin
        in_code          = pat_cnt;
        res_pat          = pat_cnt;
        res_grp_fail     = grp_fail_q;
        res_valid        = (state == S_REPORT);
        busy             = (state == S_WAIT) || (state == S_COMPARE) || (state == S_REPORT);
        done             = (state == S_DONE);
        pass             = (state == S_DONE) && (mm_cnt == '0);
        mismatch_count   = mm_cnt;
        first_fail_valid = ff_valid;
        first_fail_pat   = ff_pat;
        fail_mask        = mask_q;
    end

endmodule

// File: doc/fns_equiv_sequencer.md
# fns_equiv_sequencer

Synthesizable sequencer that drives a `fns`-style block pair (spec and translated impl) through every four-valued input pattern, waits a settle interval, and compares the two output sets bit-for-bit. It replaces the hand-written nested-loop bench for emulation and hardware-assisted equivalence runs. It sits between the two DUT instances and a result logger, and exposes a streaming per-pattern result plus a summary.

## Interface

Parameters:
- NBITS, 4, number of DUT input bits; pattern count NPAT = 4**NBITS.
- GRP_W, 4, width of one DUT output port.
- NGRP, 6, number of DUT output ports; NOUT = GRP_W*NGRP.
- SETTLE, 10, cycles `in_code` is held before compare; legal range is 1..255.

Encoding: every bit is a 2-bit code: 00=0, 01=1, 10=x, 11=z.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- abort  in  1  stop a run; go to IDLE on the next edge.
- in_code  out  2*NBITS  input code driven to both DUTs. {i0,i1,...} form; the MS digit maps to the MS input bit.
- spec_code  in  2*NOUT  spec outputs, {o1..o6} MS-first.
- impl_code  in  2*NOUT  impl outputs, same order.
- res_valid  out  1  per-pattern result available.
- res_ready  in  1  logger accepts the result.
- res_pat  out  2*NBITS  pattern index of the result.
- res_grp_fail  out  NGRP  per-port mismatch for this pattern.
- busy  out  1  run in progress.
- done  out  1  level; the run completed.
- pass  out  1  valid with done; mismatch_count==0.
- mismatch_count  out  clog2(NPAT+1)  patterns with any mismatch; saturates at NPAT.
- first_fail_valid  out  1  at least one mismatch seen.
- first_fail_pat  out  2*NBITS  lowest failing pattern index.
- fail_mask  out  NGRP  sticky OR of res_grp_fail over the run.

## Operation

- States are IDLE, WAIT, COMPARE, REPORT, DONE.
- Reset or abort:
  - Go to IDLE.
  - All outputs go to 0.
  - Pattern counter, settle counter, mismatch_count, first_fail_*, fail_mask clear.
- IDLE or DONE with start=1:
  - Clear the summary registers.
  - Load pattern 0.
  - Go to WAIT with settle counter = SETTLE-1.
  - busy=1, done=0.
- WAIT:
  - `in_code` = pattern counter.
  - Decrement the settle counter; at 0, go to COMPARE.
- COMPARE:
  - Register res_grp_fail[g] = (spec group g != impl group g) on the raw 2-bit codes. x and z are distinct; this is case-inequality.
  - Update mismatch_count (saturating), first_fail_* (only if not yet valid), and fail_mask.
  - Go to REPORT.
- REPORT:
  - res_valid=1; res_pat and res_grp_fail are held stable.
  - On res_valid&&res_ready: if the counter is NPAT-1, go to DONE; else increment the counter and go to WAIT with the settle counter reloaded.
- DONE: busy=0, done=1; the summary holds until the next start.
- start in WAIT, COMPARE or REPORT is ignored.
- abort has priority over start and over the res handshake in the same cycle.
- Pattern counter wraps never; it is bounded by the DONE transition.

## Timing

- The start edge is followed by the first WAIT cycle. `in_code` is valid from that cycle.
- spec/impl are sampled at the edge that ends COMPARE. That edge is exactly SETTLE+1 edges after `in_code` changed.
- `in_code` changes only on the REPORT→WAIT edge. It is stable through WAIT, COMPARE and REPORT.
- With res_ready held at 1, each pattern takes SETTLE+2 cycles.
- With res_ready held at 1, done rises NPAT*(SETTLE+2) edges after the first WAIT cycle. For defaults that is 3072.
- A backpressure stall extends REPORT only. No pattern is skipped or repeated.
- res_valid never drops without a handshake, except on reset or abort.
- Reset and abort take effect on the next edge, in any state.

## Structure

- Package `fns_equiv_pkg`:
  - State enum.
  - Code constants L0/L1/LX/LZ.
  - clog2-based width helpers.
- Sub-module `fns_grp_compare`: combinational, one GRP_W-bit 2-bit-code group → 1 mismatch bit. It is instantiated NGRP times.
- Everything else is in the top: FSM, counters, summary registers.

## Test plan

- Loopback (impl_code tied to spec_code), res_ready=1, defaults:
  - done rises at cycle 3072 after the first WAIT cycle.
  - pass=1, mismatch_count=0, fail_mask=0.
  - res_pat runs 00..FF contiguous.
- Impl differs from spec only at pattern 8'h1B, with o3 bit0 LX vs LZ:
  - mismatch_count=1, first_fail_pat=8'h1B.
  - fail_mask=6'b001000, where o1 is the MSB.
  - pass=0.
- res_ready low for 5 cycles at pattern 3:
  - in_code stays 3 and res_valid stays 1 for 6 cycles.
  - Next res_pat=4.
  - Total run is 3077 cycles.
- Impl always inverted on o6 bit0:
  - mismatch_count=256, first_fail_pat=0, fail_mask=6'b000001.
- abort at pattern 8'h40 in WAIT:
  - Next cycle is IDLE, busy=0, done=0, counters 0.
  - start=1 in the same cycle as abort is ignored.
- start pulsed during REPORT has no effect.
- Synchronous reset mid-COMPARE clears all outputs.
- Restart from DONE clears the summary and reruns from pattern 0.
